// File: rtl/yutorina_fetch.sv
// ============================================================================
// Module   : yutorina_fetch
// Brief    : Instruction fetch stage with a one-entry skid buffer and flush discard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yutorina_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    output logic        i_req,
    output logic [29:0] i_addr,
    input  logic        i_ack,
    input  logic [31:0] i_rdata,
    output logic        i_busy,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en_
);

    localparam logic [0:0] FETCH   = 1'b0;
    localparam logic [0:0] DISCARD = 1'b1;

    logic [0:0]  state;
    logic [29:0] pc;
    logic [29:0] discard_addr;
    logic        buf_valid;
    logic [29:0] buf_pc;
    logic [31:0] buf_insn;
    logic        ack_ok;

    // DISCARD keeps the abandoned address on the bus so the request stays stable.
    assign i_req  = ~rst & (((state == FETCH) & ~buf_valid) | (state == DISCARD));
    assign i_addr = (state == DISCARD) ? discard_addr : pc;
    assign i_busy = i_req & ~i_ack;
    assign ack_ok = i_req & i_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            discard_addr <= 30'h0;
            buf_valid    <= 1'b0;
            buf_pc       <= 30'h0;
            buf_insn     <= 32'h0;
            if_pc        <= 30'h0;
            if_insn      <= NOP_INSN;
            if_en_       <= 1'b1;
        end else if (flush) begin
            pc        <= new_pc;
            if_en_    <= 1'b1;
            if_insn   <= NOP_INSN;
            buf_valid <= 1'b0;
            if (state == FETCH && i_req && !i_ack) begin
                state        <= DISCARD;
                discard_addr <= pc;
            end else if (state == DISCARD && i_ack) begin
                state <= FETCH;
            end
        end else if (state == DISCARD) begin
            if (i_ack) begin
                state <= FETCH;
            end
        end else if (ack_ok) begin
            pc <= pc + 30'd1;
            if (stall) begin
                buf_valid <= 1'b1;
                buf_pc    <= pc;
                buf_insn  <= i_rdata;
            end else begin
                if_pc   <= pc;
                if_insn <= i_rdata;
                if_en_  <= 1'b0;
            end
        end else if (!stall) begin
            if (buf_valid) begin
                if_pc     <= buf_pc;
                if_insn   <= buf_insn;
                if_en_    <= 1'b0;
                buf_valid <= 1'b0;
            end else begin
                if_en_  <= 1'b1;
                if_insn <= NOP_INSN;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_yutorina_fetch.sv
// ============================================================================
// Module   : tb_yutorina_fetch
// Brief    : Directed self-checking bench for yutorina_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yutorina_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [29:0] new_pc;
    logic        i_req;
    logic [29:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_busy;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en_;

    int n_checks = 0;
    int n_pass   = 0;

    yutorina_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .new_pc  (new_pc),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .i_busy  (i_busy),
        .if_pc   (if_pc),
        .if_insn (if_insn),
        .if_en_  (if_en_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 30'h0;
        i_ack = 1'b0; i_rdata = 32'h0;
        tick; tick;
        check("rst_req",  {31'h0, i_req},  32'h0);
        check("rst_en",   {31'h0, if_en_}, 32'h1);
        check("rst_pc",   {2'b0, if_pc},   32'h0);
        check("rst_insn", if_insn,         32'h0);

        // zero-wait-state stream from reset
        rst = 1'b0; i_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_rdata = 32'h1000 + i;
            #1;
            check("zw_addr", {2'b0, i_addr}, i);
            check("zw_busy", {31'h0, i_busy}, 32'h0);
            tick;
            check("zw_ifpc", {2'b0, if_pc}, i);
            check("zw_insn", if_insn, 32'h1000 + i);
            check("zw_en",   {31'h0, if_en_}, 32'h0);
        end

        // two wait states on address 4
        i_ack = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            check("ws_busy", {31'h0, i_busy}, 32'h1);
            check("ws_addr", {2'b0, i_addr}, 32'h4);
            tick;
            check("ws_bubble", {31'h0, if_en_}, 32'h1);
        end
        i_ack = 1'b1; i_rdata = 32'h2004;
        #1;
        check("ws_ackbusy", {31'h0, i_busy}, 32'h0);
        check("ws_ackaddr", {2'b0, i_addr}, 32'h4);
        tick;
        check("ws_ifpc", {2'b0, if_pc}, 32'h4);
        check("ws_insn", if_insn, 32'h2004);

        // stall while address 5 returns: skid buffer holds it
        stall = 1'b1; i_rdata = 32'h3005;
        #1;
        check("st_addr", {2'b0, i_addr}, 32'h5);
        tick;
        i_ack = 1'b0;
        check("st_req",  {31'h0, i_req}, 32'h0);
        check("st_hold", {2'b0, if_pc}, 32'h4);
        check("st_en",   {31'h0, if_en_}, 32'h0);
        tick;
        check("st_req2", {31'h0, i_req}, 32'h0);
        stall = 1'b0;
        tick;
        check("st_ifpc", {2'b0, if_pc}, 32'h5);
        check("st_insn", if_insn, 32'h3005);
        check("st_en2",  {31'h0, if_en_}, 32'h0);
        check("st_req3", {31'h0, i_req}, 32'h1);
        check("st_next", {2'b0, i_addr}, 32'h6);

        // flush with the fetch of 0x8 pending three cycles
        i_ack = 1'b1; i_rdata = 32'h4006; tick;
        i_rdata = 32'h4007; tick;
        i_ack = 1'b0;
        #1;
        check("fl_addr8", {2'b0, i_addr}, 32'h8);
        flush = 1'b1; new_pc = 30'h100;
        tick;
        flush = 1'b0;
        check("fl_hold",  {2'b0, i_addr}, 32'h8);
        check("fl_req",   {31'h0, i_req}, 32'h1);
        check("fl_en",    {31'h0, if_en_}, 32'h1);
        check("fl_nop",   if_insn, 32'h0);
        tick;
        check("fl_hold2", {2'b0, i_addr}, 32'h8);
        i_ack = 1'b1; i_rdata = 32'hDEAD;
        tick;
        check("fl_drop",  {31'h0, if_en_}, 32'h1);
        check("fl_new",   {2'b0, i_addr}, 32'h100);
        i_rdata = 32'h5100;
        tick;
        check("fl_ifpc",  {2'b0, if_pc}, 32'h100);
        check("fl_insn",  if_insn, 32'h5100);
        check("fl_en2",   {31'h0, if_en_}, 32'h0);

        // flush coincident with ack
        flush = 1'b1; new_pc = 30'h40; i_rdata = 32'hBAD;
        tick;
        flush = 1'b0;
        check("fa_en",   {31'h0, if_en_}, 32'h1);
        check("fa_nop",  if_insn, 32'h0);
        check("fa_addr", {2'b0, i_addr}, 32'h40);
        check("fa_req",  {31'h0, i_req}, 32'h1);
        i_rdata = 32'h6040;
        tick;
        check("fa_ifpc", {2'b0, if_pc}, 32'h40);
        check("fa_insn", if_insn, 32'h6040);

        // pc wraparound
        flush = 1'b1; new_pc = 30'h3FFF_FFFF;
        tick;
        flush = 1'b0;
        check("wr_addr", {2'b0, i_addr}, 32'h3FFF_FFFF);
        i_rdata = 32'h7777;
        tick;
        check("wr_ifpc", {2'b0, if_pc}, 32'h3FFF_FFFF);
        check("wr_wrap", {2'b0, i_addr}, 32'h0);

        // reset abandons a pending request
        i_rdata = 32'h7000;
        tick;
        i_ack = 1'b0;
        #1;
        check("rm_addr1", {2'b0, i_addr}, 32'h1);
        tick;
        rst = 1'b1;
        tick;
        check("rm_req",  {31'h0, i_req}, 32'h0);
        check("rm_en",   {31'h0, if_en_}, 32'h1);
        check("rm_ifpc", {2'b0, if_pc}, 32'h0);
        rst = 1'b0;
        #1;
        check("rm_req2", {31'h0, i_req}, 32'h1);
        check("rm_addr", {2'b0, i_addr}, 32'h0);
        i_ack = 1'b1; i_rdata = 32'h8000;
        tick;
        check("rm_first", {2'b0, if_pc}, 32'h0);
        check("rm_insn",  if_insn, 32'h8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
